vec_instr_decoder: RTL and testbench

VEC_INSTR_DECODER -- requirements
Module: vec_instr_decoder

---
 rtl/vec_pkg.sv | 114 +++++++++++
 rtl/vec_instr_fifo.sv | 61 ++++++
 rtl/vec_instr_decoder.sv | 126 ++++++++++++
 tb/tb_vec_instr_decoder.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared constants, types and decode helpers for the vector instruction front end.
// Holds encodings, ALU codes, the control state enum and the pure decode function.
package vec_pkg;

    localparam int VLEN = 256;

    localparam logic [6:0] OPC_VEC   = 7'b1010111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000111;
    localparam logic [6:0] OPC_STORE = 7'b0100111;

    localparam logic [2:0] F3_OPIVV = 3'b000;
    localparam logic [2:0] F3_OPCFG = 3'b111;

    // Vector memory element widths carried in the funct3 slot
    localparam logic [2:0] MW_E8  = 3'b000;
    localparam logic [2:0] MW_E16 = 3'b101;
    localparam logic [2:0] MW_E32 = 3'b110;
    localparam logic [2:0] MW_E64 = 3'b111;

    localparam logic [5:0] F6_VADD = 6'b000000;
    localparam logic [5:0] F6_VSUB = 6'b000010;
    localparam logic [5:0] F6_VAND = 6'b001001;
    localparam logic [5:0] F6_VOR  = 6'b001010;
    localparam logic [5:0] F6_VXOR = 6'b001011;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_t;

    typedef enum logic [1:0] {
        CLS_ILLEGAL,
        CLS_ALU,
        CLS_LDST,
        CLS_VLEN
    } instr_class_t;

    typedef struct packed {
        instr_class_t cls;
        alu_op_t      alu_op;
        logic [4:0]   s1;
        logic [4:0]   s2;
        logic [4:0]   dest;
        logic [7:0]   vtype;
        logic [5:0]   vl;
    } decode_t;

    typedef struct packed {
        logic       is_alu;
        logic       is_ldst;
        logic       is_vlen;
        logic       illegal;
        alu_op_t    alu_op;
        logic [4:0] s1;
        logic [4:0] s2;
        logic [4:0] dest;
    } issue_t;

    // vl = min(avl, VLEN / SEW) with SEW = 8 << vsew
    function automatic logic [5:0] calc_vl(input logic [4:0] avl, input logic [2:0] vsew);
        logic [5:0] vlmax;
        vlmax = 6'(VLEN >> (3 + int'(vsew)));
        return ({1'b0, avl} < vlmax) ? {1'b0, avl} : vlmax;
    endfunction

    function automatic decode_t decode(input logic [31:0] instr);
        decode_t    d;
        logic [6:0] opcode;
        logic [2:0] funct3;
        opcode = instr[6:0];
        funct3 = instr[14:12];
        d      = '0;
        d.cls  = CLS_ILLEGAL;

        if (opcode == OPC_VEC && funct3 == F3_OPIVV && instr[25]) begin
            case (instr[31:26])
                F6_VADD: begin d.cls = CLS_ALU; d.alu_op = ALU_ADD; end
                F6_VSUB: begin d.cls = CLS_ALU; d.alu_op = ALU_SUB; end
                F6_VAND: begin d.cls = CLS_ALU; d.alu_op = ALU_AND; end
                F6_VOR:  begin d.cls = CLS_ALU; d.alu_op = ALU_OR;  end
                F6_VXOR: begin d.cls = CLS_ALU; d.alu_op = ALU_XOR; end
                default: d.cls = CLS_ILLEGAL;
            endcase
            if (d.cls == CLS_ALU) begin
                d.s1   = instr[19:15];
                d.s2   = instr[24:20];
                d.dest = instr[11:7];
            end
        end else if ((opcode == OPC_LOAD || opcode == OPC_STORE) &&
                     (funct3 == MW_E8 || funct3 == MW_E16 ||
                      funct3 == MW_E32 || funct3 == MW_E64)) begin
            d.cls  = CLS_LDST;
            d.s1   = instr[19:15];
            d.dest = instr[11:7];
        end else if (opcode == OPC_VEC && funct3 == F3_OPCFG &&
                     instr[31:30] == 2'b11 && !instr[25]) begin
            // vsew = instr[25:23]; bit 25 set means an unsupported SEW
            d.cls   = CLS_VLEN;
            d.vtype = instr[27:20];
            d.vl    = calc_vl(instr[19:15], instr[25:23]);
        end
        return d;
    endfunction

endpackage

// File: rtl/vec_instr_fifo.sv
// Synchronous show-ahead FIFO with full/empty flags; writes are refused while full,
// even when a read happens on the same edge.
module vec_instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= next_ptr(wr_ptr);
            if (do_rd) rd_ptr <= next_ptr(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; the empty flag guards
    // every read, so stale contents are never consumed.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/vec_instr_decoder.sv
// Vector instruction decoder: buffers words, pops one at a time in IDLE and holds the
// decoded issue until the controller reports completion, followed by a one-cycle gap.
module vec_instr_decoder
    import vec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [2:0]  ALU_op_to_controller,
    output logic [4:0]  address_s1_to_controller,
    output logic [4:0]  address_s2_to_controller,
    output logic [4:0]  address_destination_to_controller,
    output logic        is_alu_op,
    output logic        is_load_store_op,
    output logic        is_vlen_op,
    input  logic        op_done,
    output logic [7:0]  vtype_out,
    output logic [5:0]  vl_out,
    output logic        illegal_instr
);

    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic [31:0] head;
    decode_t     dec;
    state_t      state_q, state_d;
    issue_t      out_q, out_d;
    logic [7:0]  vtype_q, vtype_d;
    logic [5:0]  vl_q, vl_d;

    vec_instr_fifo #(
        .WIDTH (32),
        .DEPTH (4)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (instr_valid),
        .wr_data (instr_in),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign dec = decode(head);

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        out_d         = out_q;
        out_d.illegal = 1'b0;
        vtype_d       = vtype_q;
        vl_d          = vl_q;
        pop           = 1'b0;

        case (state_q)
            IDLE: begin
                out_d = '0;
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (dec.cls == CLS_ILLEGAL) begin
                        out_d.illegal = 1'b1;
                    end else begin
                        out_d.is_alu  = (dec.cls == CLS_ALU);
                        out_d.is_ldst = (dec.cls == CLS_LDST);
                        out_d.is_vlen = (dec.cls == CLS_VLEN);
                        out_d.alu_op  = dec.alu_op;
                        out_d.s1      = dec.s1;
                        out_d.s2      = dec.s2;
                        out_d.dest    = dec.dest;
                        state_d       = ISSUE;
                        if (dec.cls == CLS_VLEN) begin
                            vtype_d = dec.vtype;
                            vl_d    = dec.vl;
                        end
                    end
                end
            end
            ISSUE: begin
                if (op_done) begin
                    out_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                out_d   = '0;
                state_d = IDLE;
            end
            default: begin
                out_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            vtype_q <= '0;
            vl_q    <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            vtype_q <= vtype_d;
            vl_q    <= vl_d;
        end
    end

    assign instr_ready                       = !fifo_full;
    assign is_alu_op                         = out_q.is_alu;
    assign is_load_store_op                  = out_q.is_ldst;
    assign is_vlen_op                        = out_q.is_vlen;
    assign illegal_instr                     = out_q.illegal;
    assign ALU_op_to_controller              = out_q.alu_op;
    assign address_s1_to_controller          = out_q.s1;
    assign address_s2_to_controller          = out_q.s2;
    assign address_destination_to_controller = out_q.dest;
    assign vtype_out                         = vtype_q;
    assign vl_out                            = vl_q;

endmodule

// File: tb/tb_vec_instr_decoder.sv
// Self-checking bench for vec_instr_decoder: directed scenarios plus randomized
// instructions checked against an encoding-level reference model.
module tb_vec_instr_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  ALU_op_to_controller;
    logic [4:0]  address_s1_to_controller;
    logic [4:0]  address_s2_to_controller;
    logic [4:0]  address_destination_to_controller;
    logic        is_alu_op;
    logic        is_load_store_op;
    logic        is_vlen_op;
    logic        op_done;
    logic [7:0]  vtype_out;
    logic [5:0]  vl_out;
    logic        illegal_instr;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_vtype;
    logic [5:0] m_vl;

    // kind: 0 illegal, 1 alu, 2 load/store, 3 vsetivli
    typedef struct {
        int         kind;
        logic [2:0] alu;
        logic [4:0] s1;
        logic [4:0] s2;
        logic [4:0] d;
        logic [7:0] vtype;
        logic [5:0] vl;
    } exp_t;

    vec_instr_decoder dut (
        .clk                               (clk),
        .rst                               (rst),
        .instr_in                          (instr_in),
        .instr_valid                       (instr_valid),
        .instr_ready                       (instr_ready),
        .ALU_op_to_controller              (ALU_op_to_controller),
        .address_s1_to_controller          (address_s1_to_controller),
        .address_s2_to_controller          (address_s2_to_controller),
        .address_destination_to_controller (address_destination_to_controller),
        .is_alu_op                         (is_alu_op),
        .is_load_store_op                  (is_load_store_op),
        .is_vlen_op                        (is_vlen_op),
        .op_done                           (op_done),
        .vtype_out                         (vtype_out),
        .vl_out                            (vl_out),
        .illegal_instr                     (illegal_instr)
    );

    always #5 clk = ~clk;

    function automatic exp_t predict(input logic [31:0] w, input logic [7:0] cur_vtype,
                                     input logic [5:0] cur_vl);
        exp_t       e;
        logic [5:0] ops [5];
        int         uimm;
        int         vlmax;
        ops     = '{6'd0, 6'd2, 6'd9, 6'd10, 6'd11};
        e.kind  = 0;
        e.alu   = 3'd0;
        e.s1    = 5'd0;
        e.s2    = 5'd0;
        e.d     = 5'd0;
        e.vtype = cur_vtype;
        e.vl    = cur_vl;
        if (w[6:0] == 7'b1010111 && w[14:12] == 3'b000 && w[25]) begin
            for (int i = 0; i < 5; i++)
                if (w[31:26] == ops[i]) begin
                    e.kind = 1;
                    e.alu  = 3'(i);
                end
            if (e.kind == 1) begin
                e.s1 = w[19:15];
                e.s2 = w[24:20];
                e.d  = w[11:7];
            end
        end else if ((w[6:0] == 7'b0000111 || w[6:0] == 7'b0100111) &&
                     (w[14:12] == 3'b000 || w[14:12] >= 3'b101)) begin
            e.kind = 2;
            e.s1   = w[19:15];
            e.d    = w[11:7];
        end else if (w[6:0] == 7'b1010111 && w[14:12] == 3'b111 &&
                     w[31:30] == 2'b11 && w[25:23] <= 3'd3) begin
            e.kind  = 3;
            e.vtype = w[27:20];
            uimm    = int'(w[19:15]);
            vlmax   = 256 / (8 << int'(w[25:23]));
            e.vl    = 6'((uimm < vlmax) ? uimm : vlmax);
        end
        return e;
    endfunction

    function automatic logic [31:0] mk_alu(input logic [5:0] f6, input logic [4:0] vs2,
                                           input logic [4:0] vs1, input logic [4:0] vd);
        return {f6, 1'b1, vs2, vs1, 3'b000, vd, 7'b1010111};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [5:0]  f6s [5];
        f6s = '{6'd0, 6'd2, 6'd9, 6'd10, 6'd11};
        r   = $urandom();
        case ($urandom_range(0, 3))
            0: begin
                if ($urandom_range(0, 4) != 0) r[31:26] = f6s[$urandom_range(0, 4)];
                r[25]    = ($urandom_range(0, 5) != 0);
                r[14:12] = 3'b000;
                r[6:0]   = 7'b1010111;
            end
            1: begin
                r[14:12] = 3'($urandom_range(0, 7));
                r[6:0]   = ($urandom_range(0, 1) != 0) ? 7'b0000111 : 7'b0100111;
            end
            2: begin
                r[31:30] = 2'b11;
                r[25:23] = 3'($urandom_range(0, 4));
                r[14:12] = 3'b111;
                r[6:0]   = 7'b1010111;
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [31:0] w);
        instr_in    = w;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_is_alu"}, 32'(is_alu_op), 0);
        chk({tag, "_is_ls"}, 32'(is_load_store_op), 0);
        chk({tag, "_is_vlen"}, 32'(is_vlen_op), 0);
        chk({tag, "_alu_op"}, 32'(ALU_op_to_controller), 0);
        chk({tag, "_s1"}, 32'(address_s1_to_controller), 0);
        chk({tag, "_s2"}, 32'(address_s2_to_controller), 0);
        chk({tag, "_dest"}, 32'(address_destination_to_controller), 0);
    endtask

    task automatic chk_flags(input exp_t e, input string tag);
        chk({tag, "_is_alu"}, 32'(is_alu_op), 32'(e.kind == 1));
        chk({tag, "_is_ls"}, 32'(is_load_store_op), 32'(e.kind == 2));
        chk({tag, "_is_vlen"}, 32'(is_vlen_op), 32'(e.kind == 3));
        chk({tag, "_alu_op"}, 32'(ALU_op_to_controller), 32'(e.alu));
        if (e.kind != 3) begin
            chk({tag, "_s1"}, 32'(address_s1_to_controller), 32'(e.s1));
            chk({tag, "_s2"}, 32'(address_s2_to_controller), 32'(e.s2));
            chk({tag, "_dest"}, 32'(address_destination_to_controller), 32'(e.d));
        end
    endtask

    // Called one edge after the pop of w
    task automatic check_issued(input logic [31:0] w, input string tag, output exp_t e);
        e = predict(w, m_vtype, m_vl);
        if (e.kind == 0) begin
            chk({tag, "_illegal"}, 32'(illegal_instr), 1);
            chk_idle_outputs({tag, "_illegal"});
        end else begin
            chk({tag, "_illegal"}, 32'(illegal_instr), 0);
            chk_flags(e, tag);
        end
        chk({tag, "_vtype"}, 32'(vtype_out), 32'(e.vtype));
        chk({tag, "_vl"}, 32'(vl_out), 32'(e.vl));
        m_vtype = e.vtype;
        m_vl    = e.vl;
    endtask

    task automatic finish_issue(input exp_t e, input int hold, input bit long_done,
                                input string tag);
        for (int i = 0; i < hold; i++) begin
            step();
            chk_flags(e, {tag, "_hold"});
        end
        op_done = 1'b1;
        step();
        if (!long_done) op_done = 1'b0;
        chk_idle_outputs({tag, "_gap"});
        step();
        op_done = 1'b0;
        chk_idle_outputs({tag, "_idle"});
        chk({tag, "_idle_illegal"}, 32'(illegal_instr), 0);
    endtask

    task automatic run_one(input logic [31:0] w, input int hold, input bit long_done,
                           input string tag);
        exp_t e;
        push(w);
        chk_idle_outputs({tag, "_latency"});
        step();
        check_issued(w, tag, e);
        if (e.kind == 0) begin
            step();
            chk({tag, "_pulse_end"}, 32'(illegal_instr), 0);
            chk_idle_outputs({tag, "_after_illegal"});
        end else begin
            finish_issue(e, hold, long_done, tag);
        end
    endtask

    initial begin
        exp_t        e;
        logic [31:0] q [5];
        logic [31:0] w;

        rst         = 1'b1;
        instr_valid = 1'b0;
        instr_in    = '0;
        op_done     = 1'b0;
        m_vtype     = '0;
        m_vl        = '0;

        // Reset state
        step();
        step();
        chk_idle_outputs("reset");
        chk("reset_vtype", 32'(vtype_out), 0);
        chk("reset_vl", 32'(vl_out), 0);
        chk("reset_illegal", 32'(illegal_instr), 0);
        rst = 1'b0;
        step();
        chk("ready_after_reset", 32'(instr_ready), 1);

        // vadd.vv v3, v1, v2 with fixed expectations
        push(32'h022081D7);
        chk("vadd_latency_edge1", 32'(is_alu_op), 0);
        step();
        chk("vadd_is_alu", 32'(is_alu_op), 1);
        chk("vadd_is_ls", 32'(is_load_store_op), 0);
        chk("vadd_is_vlen", 32'(is_vlen_op), 0);
        chk("vadd_alu_op", 32'(ALU_op_to_controller), 0);
        chk("vadd_s1", 32'(address_s1_to_controller), 1);
        chk("vadd_s2", 32'(address_s2_to_controller), 2);
        chk("vadd_dest", 32'(address_destination_to_controller), 3);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("vadd_hold_alu", 32'(is_alu_op), 1);
            chk("vadd_hold_dest", 32'(address_destination_to_controller), 3);
        end
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        chk("vadd_gap_alu", 32'(is_alu_op), 0);
        chk("vadd_gap_s1", 32'(address_s1_to_controller), 0);
        step();
        chk("vadd_idle_alu", 32'(is_alu_op), 0);

        // vsetivli 20, e32
        push(32'hC10A7057);
        step();
        chk("vset_is_vlen", 32'(is_vlen_op), 1);
        chk("vset_is_alu", 32'(is_alu_op), 0);
        chk("vset_alu_op", 32'(ALU_op_to_controller), 0);
        chk("vset_vtype", 32'(vtype_out), 32'h10);
        chk("vset_vl", 32'(vl_out), 8);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("vset_hold", 32'(is_vlen_op), 1);
        end
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        chk("vset_gap_vlen", 32'(is_vlen_op), 0);
        chk("vset_vtype_kept", 32'(vtype_out), 32'h10);
        step();
        m_vtype = 8'h10;
        m_vl    = 6'd8;

        // All-ones word is illegal, then a normal issue
        push(32'hFFFFFFFF);
        step();
        chk("ill_pulse", 32'(illegal_instr), 1);
        chk_idle_outputs("ill");
        chk("ill_vtype", 32'(vtype_out), 32'h10);
        chk("ill_vl", 32'(vl_out), 8);
        step();
        chk("ill_pulse_end", 32'(illegal_instr), 0);
        chk_idle_outputs("ill_after");
        run_one(mk_alu(6'b001011, 5'd7, 5'd6, 5'd5), 2, 1'b0, "after_ill");

        // op_done outside ISSUE has no effect
        op_done = 1'b1;
        step();
        step();
        op_done = 1'b0;
        chk_idle_outputs("opdone_idle");
        chk("opdone_idle_illegal", 32'(illegal_instr), 0);
        run_one(mk_alu(6'b000010, 5'd9, 5'd8, 5'd10), 2, 1'b1, "vsub_long_done");
        run_one(mk_alu(6'b001001, 5'd12, 5'd11, 5'd13), 2, 1'b0, "vand_after_gap");

        // FIFO full while an issue is blocked
        push(mk_alu(6'b001010, 5'd1, 5'd2, 5'd31));
        step();
        check_issued(mk_alu(6'b001010, 5'd1, 5'd2, 5'd31), "full_a", e);
        for (int i = 0; i < 5; i++)
            q[i] = mk_alu(6'b000000, 5'(i + 1), 5'(i + 2), 5'(i + 20));
        for (int i = 0; i < 4; i++) begin
            instr_in    = q[i];
            instr_valid = 1'b1;
            step();
            chk("full_ready_fill", 32'(instr_ready), (i < 3) ? 1 : 0);
        end
        instr_in = q[4];
        step();
        step();
        chk("full_stalled_ready", 32'(instr_ready), 0);
        chk("full_a_still_issued", 32'(is_alu_op), 1);
        chk("full_a_dest", 32'(address_destination_to_controller), 31);
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        chk("full_gap_ready", 32'(instr_ready), 0);
        chk("full_gap_alu", 32'(is_alu_op), 0);
        step();
        chk("full_idle_ready", 32'(instr_ready), 0);
        step();
        check_issued(q[0], "full_b", e);
        chk("full_ready_after_pop", 32'(instr_ready), 1);
        step();
        chk("full_fifth_accepted", 32'(instr_ready), 0);
        instr_valid = 1'b0;
        chk_flags(e, "full_b_held");
        finish_issue(e, 0, 1'b0, "full_b");
        for (int i = 1; i < 5; i++) begin
            step();
            check_issued(q[i], "full_drain", e);
            finish_issue(e, 1, 1'b0, "full_drain");
        end
        chk("full_drained_ready", 32'(instr_ready), 1);

        // Randomized instructions
        for (int n = 0; n < 40; n++) begin
            w = gen_instr();
            run_one(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand");
        end

        // Reset in the middle of an issue with buffered work
        push(32'hC10A7057);
        step();
        check_issued(32'hC10A7057, "rst_vset", e);
        push(q[0]);
        push(q[1]);
        chk("rst_pre_vlen", 32'(is_vlen_op), 1);
        rst = 1'b1;
        #2;
        chk_idle_outputs("rst_mid");
        chk("rst_mid_vtype", 32'(vtype_out), 0);
        chk("rst_mid_vl", 32'(vl_out), 0);
        chk("rst_mid_illegal", 32'(illegal_instr), 0);
        chk("rst_mid_ready", 32'(instr_ready), 1);
        step();
        rst     = 1'b0;
        m_vtype = '0;
        m_vl    = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle_outputs("rst_fifo_empty");
            chk("rst_fifo_empty_illegal", 32'(illegal_instr), 0);
            chk("rst_ready", 32'(instr_ready), 1);
        end
        run_one(32'h022081D7, 1, 1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
